// File: rtl/net2_sync_filter_if.sv
// net2_sync_filter_if
// Carries the two raw nets into the sync/debounce stage and the
// filtered levels and edge pulses back out.
//   IN1, IN2        raw asynchronous nets (driven by master)
//   OUT1, OUT2      filtered levels
//   RISE1/FALL1     one-cycle edge pulses, channel 1
//   RISE2/FALL2     one-cycle edge pulses, channel 2
//   CHANGE          OR of the four edge pulses
// The master modport is the side that drives the raw nets.
// The slave modport is the filter itself.
interface net2_sync_filter_if;
    logic IN1;
    logic IN2;
    logic OUT1;
    logic OUT2;
    logic RISE1;
    logic FALL1;
    logic RISE2;
    logic FALL2;
    logic CHANGE;

    modport master (
        output IN1, IN2,
        input  OUT1, OUT2, RISE1, FALL1, RISE2, FALL2, CHANGE
    );

    modport slave (
        input  IN1, IN2,
        output OUT1, OUT2, RISE1, FALL1, RISE2, FALL2, CHANGE
    );
endinterface

// File: rtl/net2_sync_filter.sv
// net2_sync_filter
// Two independent channels. Each channel takes one raw asynchronous net
// through a SYNC_STAGES-deep synchronizer and then a debounce filter.
// The filter accepts a new level only after DEBOUNCE_CYCLES consecutive
// mismatching synchronized samples.
//   CLK   single clock
//   nRST  asynchronous reset, active-low
//   bus   slave side of net2_sync_filter_if:
//         IN1/IN2 raw nets in
//         OUT1/OUT2 filtered levels out
//         RISEx/FALLx and CHANGE one-cycle registered pulses out
// Every output is a flop, so no combinational path runs from IN to any output.
module net2_sync_filter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    net2_sync_filter_if.slave    bus
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] out_lvl;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       change_q;

    assign raw = {bus.IN2, bus.IN1};

    for (genvar ch = 0; ch < 2; ch++) begin : ch_g
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   out_q, out_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   s_n;

        assign s_n = sync_q[SYNC_STAGES-1];

        always_comb begin
            cnt_d  = cnt_q;
            out_d  = out_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (s_n == out_q) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                out_d  = s_n;
                cnt_d  = '0;
                rise_d = s_n;
                fall_d = ~s_n;
            end
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                sync_q <= '0;
                cnt_q  <= '0;
                out_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[ch]};
                cnt_q  <= cnt_d;
                out_q  <= out_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        end

        assign out_lvl[ch] = out_q;
        assign rise[ch]    = rise_q;
        assign fall[ch]    = fall_q;
    end

    // CHANGE is registered from the next-state pulses.
    // This keeps it on the same edge as the RISE/FALL flops.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            change_q <= 1'b0;
        end else begin
            change_q <= ch_g[0].rise_d | ch_g[0].fall_d |
                        ch_g[1].rise_d | ch_g[1].fall_d;
        end
    end

    assign bus.OUT1   = out_lvl[0];
    assign bus.OUT2   = out_lvl[1];
    assign bus.RISE1  = rise[0];
    assign bus.FALL1  = fall[0];
    assign bus.RISE2  = rise[1];
    assign bus.FALL2  = fall[1];
    assign bus.CHANGE = change_q;

endmodule
